// File: rtl/rf_seq_reader.sv
// rf_seq_reader: sequenced register-file read unit for the ID/RFR stage.
// Holds a 1R/1W synchronous register array and fetches NRS source operands
// serially through its single read port. Writebacks in the issue or capture
// cycle are forwarded so captured operands are never stale. Stall aborts.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   stall              aborts a fetch in ADR or non-final CAP
//   start, rs_adr      fetch request and packed source addresses (k at [k*AW +: AW])
//   wb_en/adr/data     writeback port into the array
//   busy               state is not IDLE
//   done               one-cycle pulse after the final capture
//   rs_data            packed operands (k at [k*XLEN +: XLEN])
module rf_seq_reader #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned AW       = $clog2(NREG),
  parameter int unsigned NRS      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                start,
  input  logic [NRS*AW-1:0]   rs_adr,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_adr,
  input  logic [XLEN-1:0]     wb_data,
  output logic                busy,
  output logic                done,
  output logic [NRS*XLEN-1:0] rs_data
);

  localparam int unsigned CW = (NRS > 1) ? $clog2(NRS) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(NRS - 1);

  typedef enum logic [1:0] {StIdle, StAdr, StCap} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   adr_q [NRS];
  logic [XLEN-1:0] rs_q [NRS];
  logic            done_q;

  logic [XLEN-1:0] mem [NREG];
  logic [XLEN-1:0] rd_q;
  logic            byp_q;
  logic [XLEN-1:0] byp_data_q;

  logic [AW-1:0]   issue_adr;
  logic [AW-1:0]   cap_adr;
  logic [XLEN-1:0] cap_data;

  // Address presented to the read port this cycle: adr_q[0] in ADR, adr_q[k+1] in CAP k.
  always_comb begin
    issue_adr = adr_q[0];
    if (state_q == StCap) begin
      for (int k = 0; k < int'(NRS) - 1; k++) begin
        if (cnt_q == CW'(k)) issue_adr = adr_q[k+1];
      end
    end
  end

  // Operand being captured this cycle and its forwarded value.
  always_comb begin
    cap_adr = adr_q[0];
    for (int k = 0; k < int'(NRS); k++) begin
      if (cnt_q == CW'(k)) cap_adr = adr_q[k];
    end
    if (ZERO_REG != 0 && cap_adr == '0) begin
      cap_data = '0;
    end else if (wb_en && wb_adr == cap_adr) begin
      cap_data = wb_data;
    end else if (byp_q) begin
      cap_data = byp_data_q;
    end else begin
      cap_data = rd_q;
    end
  end

  // Array: read-before-write, contents intentionally not reset.
  always_ff @(posedge clk) begin
    if (wb_en && !(ZERO_REG != 0 && wb_adr == '0)) mem[wb_adr] <= wb_data;
    rd_q       <= mem[issue_adr];
    byp_data_q <= wb_data;
  end

  // Bypass flag: a write landed on the issued address at the same edge as the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_q <= 1'b0;
    end else begin
      byp_q <= wb_en && (wb_adr == issue_adr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < int'(NRS); k++) begin
        adr_q[k] <= '0;
        rs_q[k]  <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !stall) begin
            for (int k = 0; k < int'(NRS); k++) adr_q[k] <= rs_adr[k*AW +: AW];
            state_q <= StAdr;
          end
        end
        StAdr: begin
          cnt_q   <= '0;
          state_q <= stall ? StIdle : StCap;
        end
        StCap: begin
          for (int k = 0; k < int'(NRS); k++) begin
            if (cnt_q == CW'(k)) rs_q[k] <= cap_data;
          end
          // Final capture always completes; stall only aborts earlier ones.
          if (cnt_q == LastCnt) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else if (stall) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;

  for (genvar g = 0; g < int'(NRS); g++) begin : g_out
    assign rs_data[g*XLEN +: XLEN] = rs_q[g];
  end

endmodule

// File: tb/tb_rf_seq_reader.sv
module tb_rf_seq_reader;

  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_adr = '0;
  logic [31:0] wb_data = '0;

  logic        start2 = 1'b0;
  logic [9:0]  rs_adr2 = '0;
  logic        busy2, done2;
  logic [63:0] rs_data2;

  logic        start3 = 1'b0;
  logic [14:0] rs_adr3 = '0;
  logic        busy3, done3;
  logic [95:0] rs_data3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_seq_reader #(.XLEN(32), .NREG(32), .NRS(2), .ZERO_REG(1)) u2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .start(start2), .rs_adr(rs_adr2),
    .wb_en(wb_en), .wb_adr(wb_adr), .wb_data(wb_data),
    .busy(busy2), .done(done2), .rs_data(rs_data2)
  );

  rf_seq_reader #(.XLEN(32), .NREG(32), .NRS(3), .ZERO_REG(1)) u3 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .start(start3), .rs_adr(rs_adr3),
    .wb_en(wb_en), .wb_adr(wb_adr), .wb_data(wb_data),
    .busy(busy3), .done(done3), .rs_data(rs_data3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1;
    wb_adr = a;
    wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  // Full NRS=2 fetch; checks latency from accept to done and the operands.
  task automatic fetch2(input string name, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] e0, input logic [31:0] e1);
    int n;
    rs_adr2 = {a1, a0};
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 10) begin
      step();
      n++;
    end
    chk({name, "_done"}, done2, 1);
    chk({name, "_lat"}, n, 3);
    chk({name, "_data"}, rs_data2, {e1, e0});
  endtask

  typedef struct {
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t1, t2, nd;
    logic [95:0] d1, d2;

    vecs[0] = '{a0: 5'd0, a1: 5'd0, e0: 32'h0,        e1: 32'h0};
    vecs[1] = '{a0: 5'd5, a1: 5'd5, e0: 32'hDEADBEEF, e1: 32'hDEADBEEF};
    vecs[2] = '{a0: 5'd3, a1: 5'd9, e0: 32'h33,       e1: 32'h12345678};
    vecs[3] = '{a0: 5'd0, a1: 5'd5, e0: 32'h0,        e1: 32'hDEADBEEF};
    vecs[4] = '{a0: 5'd9, a1: 5'd3, e0: 32'h12345678, e1: 32'h33};

    // Reset state
    step();
    step();
    chk("rst_busy", busy2, 0);
    chk("rst_done", done2, 0);
    chk("rst_data", rs_data2, 64'h0);
    rst_n = 1'b1;
    step();
    chk("rst_data3", rs_data3, 96'h0);

    wr(5'd5, 32'hDEADBEEF);
    wr(5'd9, 32'h12345678);
    wr(5'd0, 32'hFFFFFFFF);
    wr(5'd3, 32'h33);
    wr(5'd7, 32'h1);

    // Basic fetch with cycle-by-cycle busy/done
    rs_adr2 = {5'd9, 5'd5};
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("basic_busy1", {busy2, done2}, 2'b10);
    step();
    chk("basic_busy2", {busy2, done2}, 2'b10);
    step();
    chk("basic_busy3", {busy2, done2}, 2'b10);
    step();
    chk("basic_done", {busy2, done2}, 2'b01);
    chk("basic_data", rs_data2, {32'h12345678, 32'hDEADBEEF});
    step();
    chk("basic_done_pulse", done2, 0);

    for (int i = 0; i < 5; i++) begin
      fetch2($sformatf("vec%0d", i), vecs[i].a0, vecs[i].a1, vecs[i].e0, vecs[i].e1);
      step();
    end

    // start with stall is dropped
    rs_adr2 = {5'd5, 5'd5};
    start2 = 1'b1;
    stall = 1'b1;
    step();
    start2 = 1'b0;
    stall = 1'b0;
    chk("stall_start_drop", busy2, 0);
    step();

    // NRS=3 back-to-back, start held high; rs_adr changed while busy
    rs_adr3 = {5'd3, 5'd9, 5'd5};
    start3 = 1'b1;
    nd = 0;
    t1 = 0;
    t2 = 0;
    d1 = '0;
    d2 = '0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      if (cyc == 1) rs_adr3 = {5'd9, 5'd0, 5'd7};
      if (done3) begin
        if (nd == 0) begin
          t1 = cyc;
          d1 = rs_data3;
        end else if (nd == 1) begin
          t2 = cyc;
          d2 = rs_data3;
          start3 = 1'b0;
        end
        nd++;
      end
    end
    start3 = 1'b0;
    chk("b2b_first_done", t1, 5);
    chk("b2b_spacing", t2 - t1, 5);
    chk("b2b_count", nd, 2);
    chk("b2b_data1", d1, {32'h33, 32'h12345678, 32'hDEADBEEF});
    chk("b2b_data2", d2, {32'h12345678, 32'h0, 32'h1});

    // Issue-cycle forwarding: write x7 during ADR
    rs_adr2 = {5'd3, 5'd7};
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    wb_en = 1'b1;
    wb_adr = 5'd7;
    wb_data = 32'hA5A5A5A5;
    step();
    wb_en = 1'b0;
    step();
    step();
    chk("fwd_issue_done", done2, 1);
    chk("fwd_issue_data", rs_data2, {32'h33, 32'hA5A5A5A5});
    step();

    // Capture-cycle forwarding: write x7 during CAP0
    rs_adr2 = {5'd3, 5'd7};
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    step();
    wb_en = 1'b1;
    wb_adr = 5'd7;
    wb_data = 32'h5A5A5A5A;
    step();
    wb_en = 1'b0;
    step();
    chk("fwd_cap_done", done2, 1);
    chk("fwd_cap_data", rs_data2, {32'h33, 32'h5A5A5A5A});
    step();

    // Stall in CAP0 aborts: operand 0 updated, operand 1 kept, no done
    rs_adr2 = {5'd5, 5'd9};
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    step();
    stall = 1'b1;
    step();
    stall = 1'b0;
    chk("abort_state", {busy2, done2}, 2'b00);
    chk("abort_data", rs_data2, {32'h33, 32'h12345678});
    step();
    chk("abort_no_done", done2, 0);

    // Stall in final CAP is ignored
    rs_adr2 = {5'd5, 5'd3};
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    step();
    step();
    stall = 1'b1;
    step();
    stall = 1'b0;
    chk("last_stall_done", {busy2, done2}, 2'b01);
    chk("last_stall_data", rs_data2, {32'hDEADBEEF, 32'h33});
    step();

    // Async reset during CAP1
    rs_adr2 = {5'd9, 5'd5};
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("areset_busy", busy2, 0);
    chk("areset_data", rs_data2, 64'h0);
    step();
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done2) nd++;
    end
    chk("areset_no_done", nd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
